// File: rtl/friscv_pkg.sv
// Shared FRISCV definitions: AXI response codes, write-buffer drain states and
// the helper that turns a data-bus width into a block-offset width.
package friscv_pkg;

   localparam logic [1:0] AxiRespOkay   = 2'b00;
   localparam logic [1:0] AxiRespExOkay = 2'b01;
   localparam logic [1:0] AxiRespSlvErr = 2'b10;
   localparam logic [1:0] AxiRespDecErr = 2'b11;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWaitB
   } wbuf_state_e;

   function automatic int unsigned blk_off_w(input int unsigned data_w);
      return $clog2(data_w / 8);
   endfunction

endpackage

// File: rtl/friscv_wbuf_entry.sv
// One write-buffer slot: block tag, protection, data, byte strobes and age,
// with byte-granular merge of later writes to the same block.
module friscv_wbuf_entry #(
   parameter int unsigned BLK_W  = 28,
   parameter int unsigned DATA_W = 128,
   parameter int unsigned AGE_W  = 2
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  srst,
   input  logic                  alloc_i,
   input  logic                  merge_i,
   input  logic                  drain_i,
   input  logic                  free_i,
   input  logic [BLK_W-1:0]      blk_i,
   input  logic [2:0]            prot_i,
   input  logic [DATA_W-1:0]     data_i,
   input  logic [DATA_W/8-1:0]   strb_i,
   input  logic [AGE_W-1:0]      age_i,
   output logic                  valid_o,
   output logic                  draining_o,
   output logic [BLK_W-1:0]      blk_o,
   output logic [2:0]            prot_o,
   output logic [DATA_W-1:0]     data_o,
   output logic [DATA_W/8-1:0]   strb_o,
   output logic [AGE_W-1:0]      age_o
);

   logic                valid_q;
   logic                draining_q;
   logic [BLK_W-1:0]    blk_q;
   logic [2:0]          prot_q;
   logic [DATA_W-1:0]   data_q;
   logic [DATA_W-1:0]   data_merge;
   logic [DATA_W/8-1:0] strb_q;
   logic [AGE_W-1:0]    age_q;

   always_comb begin
      data_merge = data_q;
      for (int i = 0; i < DATA_W / 8; i++) begin
         if (strb_i[i]) data_merge[8*i +: 8] = data_i[8*i +: 8];
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         valid_q    <= 1'b0;
         draining_q <= 1'b0;
         blk_q      <= '0;
         prot_q     <= '0;
         data_q     <= '0;
         strb_q     <= '0;
         age_q      <= '0;
      end else if (srst) begin
         valid_q    <= 1'b0;
         draining_q <= 1'b0;
         blk_q      <= '0;
         prot_q     <= '0;
         data_q     <= '0;
         strb_q     <= '0;
         age_q      <= '0;
      end else begin
         if (free_i) begin
            valid_q    <= 1'b0;
            draining_q <= 1'b0;
         end else if (drain_i) begin
            draining_q <= 1'b1;
         end
         if (alloc_i) begin
            valid_q    <= 1'b1;
            draining_q <= 1'b0;
            blk_q      <= blk_i;
            prot_q     <= prot_i;
            data_q     <= data_i;
            strb_q     <= strb_i;
            age_q      <= age_i;
         end else if (merge_i) begin
            data_q <= data_merge;
            strb_q <= strb_q | strb_i;
         end
      end
   end

   assign valid_o    = valid_q;
   assign draining_o = draining_q;
   assign blk_o      = blk_q;
   assign prot_o     = prot_q;
   assign data_o     = data_q;
   assign strb_o     = strb_q;
   assign age_o      = age_q;

endmodule

// File: rtl/friscv_dcache_wbuf.sv
// Posted write buffer between the dcache and memory: merges writes per block,
// drains oldest-first one burst at a time, and holds reads that hit pending data.
module friscv_dcache_wbuf
   import friscv_pkg::*;
#(
   parameter int unsigned AXI_ADDR_W = 32,
   parameter int unsigned AXI_ID_W   = 8,
   parameter int unsigned AXI_DATA_W = 128,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                    aclk,
   input  logic                    aresetn,
   input  logic                    srst,
   input  logic                    s_awvalid,
   output logic                    s_awready,
   input  logic [AXI_ADDR_W-1:0]   s_awaddr,
   input  logic [2:0]              s_awprot,
   input  logic [AXI_ID_W-1:0]     s_awid,
   input  logic                    s_wvalid,
   output logic                    s_wready,
   input  logic [AXI_DATA_W-1:0]   s_wdata,
   input  logic [AXI_DATA_W/8-1:0] s_wstrb,
   output logic                    s_bvalid,
   input  logic                    s_bready,
   output logic [AXI_ID_W-1:0]     s_bid,
   output logic [1:0]              s_bresp,
   input  logic                    s_arvalid,
   output logic                    s_arready,
   input  logic [AXI_ADDR_W-1:0]   s_araddr,
   input  logic [2:0]              s_arprot,
   input  logic [AXI_ID_W-1:0]     s_arid,
   output logic                    s_rvalid,
   input  logic                    s_rready,
   output logic [AXI_ID_W-1:0]     s_rid,
   output logic [1:0]              s_rresp,
   output logic [AXI_DATA_W-1:0]   s_rdata,
   output logic                    m_awvalid,
   input  logic                    m_awready,
   output logic [AXI_ADDR_W-1:0]   m_awaddr,
   output logic [2:0]              m_awprot,
   output logic [AXI_ID_W-1:0]     m_awid,
   output logic                    m_wvalid,
   input  logic                    m_wready,
   output logic [AXI_DATA_W-1:0]   m_wdata,
   output logic [AXI_DATA_W/8-1:0] m_wstrb,
   input  logic                    m_bvalid,
   output logic                    m_bready,
   input  logic [AXI_ID_W-1:0]     m_bid,
   input  logic [1:0]              m_bresp,
   output logic                    m_arvalid,
   input  logic                    m_arready,
   output logic [AXI_ADDR_W-1:0]   m_araddr,
   output logic [2:0]              m_arprot,
   output logic [AXI_ID_W-1:0]     m_arid,
   input  logic                    m_rvalid,
   output logic                    m_rready,
   input  logic [AXI_ID_W-1:0]     m_rid,
   input  logic [1:0]              m_rresp,
   input  logic [AXI_DATA_W-1:0]   m_rdata,
   output logic                    empty,
   output logic                    wr_error
);

   localparam int unsigned OFF_W  = blk_off_w(AXI_DATA_W);
   localparam int unsigned BLK_W  = AXI_ADDR_W - OFF_W;
   localparam int unsigned STRB_W = AXI_DATA_W / 8;
   localparam int unsigned IDX_W  = $clog2(DEPTH);

   logic [DEPTH-1:0]      ent_valid, ent_drain;
   logic [DEPTH-1:0]      ent_alloc, ent_merge, ent_drain_set, ent_free;
   logic [BLK_W-1:0]      ent_blk  [DEPTH];
   logic [2:0]            ent_prot [DEPTH];
   logic [AXI_DATA_W-1:0] ent_data [DEPTH];
   logic [STRB_W-1:0]     ent_strb [DEPTH];
   logic [IDX_W-1:0]      ent_age  [DEPTH];

   wbuf_state_e      state_q;
   logic [IDX_W-1:0] sel_q, head_q, age_q;
   logic             awvalid_q, wvalid_q, bvalid_q, wr_error_q;
   logic [AXI_ID_W-1:0] bid_q;

   logic [BLK_W-1:0] w_blk, ar_blk;
   logic             hit, ar_hit, free_found, old_found;
   logic [IDX_W-1:0] hit_idx, free_idx, old_idx;
   logic             wr_ready, accept, aw_done, w_done;
   logic             unused_bits;

   assign w_blk  = s_awaddr[AXI_ADDR_W-1:OFF_W];
   assign ar_blk = s_araddr[AXI_ADDR_W-1:OFF_W];

   // Ages are handed out in allocation order and entries retire in that order,
   // so the oldest live entry is always the one whose age equals head_q.
   always_comb begin
      hit        = 1'b0;
      hit_idx    = '0;
      ar_hit     = 1'b0;
      free_found = 1'b0;
      free_idx   = '0;
      old_found  = 1'b0;
      old_idx    = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_valid[i] && !ent_drain[i] && ent_blk[i] == w_blk) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(i);
         end
         if (ent_valid[i] && ent_blk[i] == ar_blk) ar_hit = 1'b1;
         if (!ent_valid[i] && !free_found) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
         if (ent_valid[i] && ent_age[i] == head_q && !old_found) begin
            old_found = 1'b1;
            old_idx   = IDX_W'(i);
         end
      end
   end

   assign wr_ready = (hit || free_found) && !bvalid_q;
   assign accept   = s_awvalid && s_wvalid && wr_ready;
   assign aw_done  = !awvalid_q || m_awready;
   assign w_done   = !wvalid_q || m_wready;

   for (genvar g = 0; g < DEPTH; g++) begin : g_entry
      assign ent_alloc[g]     = accept && !hit && (free_idx == IDX_W'(g));
      assign ent_merge[g]     = accept && hit && (hit_idx == IDX_W'(g));
      assign ent_drain_set[g] = (state_q == StIdle) && old_found && (old_idx == IDX_W'(g));
      assign ent_free[g]      = (state_q == StWaitB) && m_bvalid && (sel_q == IDX_W'(g));

      friscv_wbuf_entry #(
         .BLK_W  (BLK_W),
         .DATA_W (AXI_DATA_W),
         .AGE_W  (IDX_W)
      ) u_entry (
         .aclk       (aclk),
         .aresetn    (aresetn),
         .srst       (srst),
         .alloc_i    (ent_alloc[g]),
         .merge_i    (ent_merge[g]),
         .drain_i    (ent_drain_set[g]),
         .free_i     (ent_free[g]),
         .blk_i      (w_blk),
         .prot_i     (s_awprot),
         .data_i     (s_wdata),
         .strb_i     (s_wstrb),
         .age_i      (age_q),
         .valid_o    (ent_valid[g]),
         .draining_o (ent_drain[g]),
         .blk_o      (ent_blk[g]),
         .prot_o     (ent_prot[g]),
         .data_o     (ent_data[g]),
         .strb_o     (ent_strb[g]),
         .age_o      (ent_age[g])
      );
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         bvalid_q <= 1'b0;
         bid_q    <= '0;
         age_q    <= '0;
      end else if (srst) begin
         bvalid_q <= 1'b0;
         bid_q    <= '0;
         age_q    <= '0;
      end else begin
         if (accept) begin
            bvalid_q <= 1'b1;
            bid_q    <= s_awid;
         end else if (s_bready) begin
            bvalid_q <= 1'b0;
         end
         if (accept && !hit) age_q <= age_q + 1'b1;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q    <= StIdle;
         sel_q      <= '0;
         head_q     <= '0;
         awvalid_q  <= 1'b0;
         wvalid_q   <= 1'b0;
         wr_error_q <= 1'b0;
      end else if (srst) begin
         state_q    <= StIdle;
         sel_q      <= '0;
         head_q     <= '0;
         awvalid_q  <= 1'b0;
         wvalid_q   <= 1'b0;
         wr_error_q <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (old_found) begin
                  sel_q     <= old_idx;
                  awvalid_q <= 1'b1;
                  wvalid_q  <= 1'b1;
                  state_q   <= StIssue;
               end
            end
            StIssue: begin
               if (m_awready) awvalid_q <= 1'b0;
               if (m_wready) wvalid_q <= 1'b0;
               if (aw_done && w_done) state_q <= StWaitB;
            end
            StWaitB: begin
               if (m_bvalid) begin
                  state_q <= StIdle;
                  head_q  <= head_q + 1'b1;
                  if (m_bresp != AxiRespOkay) wr_error_q <= 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign s_awready = wr_ready;
   assign s_wready  = wr_ready;
   assign s_bvalid  = bvalid_q;
   assign s_bid     = bid_q;
   assign s_bresp   = AxiRespOkay;

   assign m_awvalid = awvalid_q;
   assign m_awaddr  = {ent_blk[sel_q], {OFF_W{1'b0}}};
   assign m_awprot  = ent_prot[sel_q];
   assign m_awid    = '0;
   assign m_wvalid  = wvalid_q;
   assign m_wdata   = ent_data[sel_q];
   assign m_wstrb   = ent_strb[sel_q];
   assign m_bready  = 1'b1;

   // Reads to a block still held here would see stale memory, so they wait.
   assign m_arvalid = s_arvalid && !ar_hit;
   assign s_arready = m_arready && !ar_hit;
   assign m_araddr  = s_araddr;
   assign m_arprot  = s_arprot;
   assign m_arid    = s_arid;

   assign s_rvalid  = m_rvalid;
   assign m_rready  = s_rready;
   assign s_rid     = m_rid;
   assign s_rresp   = m_rresp;
   assign s_rdata   = m_rdata;

   assign empty    = !(|ent_valid) && (state_q == StIdle);
   assign wr_error = wr_error_q;

   assign unused_bits = ^{m_bid, s_awaddr[OFF_W-1:0]};

endmodule

// File: tb/tb_friscv_dcache_wbuf.sv
// Directed bench for friscv_dcache_wbuf with a small AXI memory model behind it.
module tb_friscv_dcache_wbuf;

   logic         aclk = 1'b0;
   logic         aresetn, srst;
   logic         s_awvalid, s_awready, s_wvalid, s_wready;
   logic [31:0]  s_awaddr;
   logic [2:0]   s_awprot;
   logic [7:0]   s_awid;
   logic [127:0] s_wdata;
   logic [15:0]  s_wstrb;
   logic         s_bvalid, s_bready;
   logic [7:0]   s_bid;
   logic [1:0]   s_bresp;
   logic         s_arvalid, s_arready;
   logic [31:0]  s_araddr;
   logic [2:0]   s_arprot;
   logic [7:0]   s_arid;
   logic         s_rvalid, s_rready;
   logic [7:0]   s_rid;
   logic [1:0]   s_rresp;
   logic [127:0] s_rdata;
   logic         m_awvalid, m_awready, m_wvalid, m_wready;
   logic [31:0]  m_awaddr;
   logic [2:0]   m_awprot;
   logic [7:0]   m_awid;
   logic [127:0] m_wdata;
   logic [15:0]  m_wstrb;
   logic         m_bvalid, m_bready;
   logic [7:0]   m_bid;
   logic [1:0]   m_bresp;
   logic         m_arvalid, m_arready;
   logic [31:0]  m_araddr;
   logic [2:0]   m_arprot;
   logic [7:0]   m_arid;
   logic         m_rvalid, m_rready;
   logic [7:0]   m_rid;
   logic [1:0]   m_rresp;
   logic [127:0] m_rdata;
   logic         empty, wr_error;

   int n_cmp = 0;
   int n_bad = 0;

   // Memory model controls and observations
   logic         aw_rdy = 1'b1, w_rdy = 1'b1, b_en = 1'b1;
   logic [1:0]   b_resp_cfg = 2'b00;
   logic         aw_done = 1'b0, w_done = 1'b0, bv = 1'b0, rv = 1'b0;
   logic [127:0] rd = '0;
   logic [127:0] mem [256];
   int           aw_cnt = 0, b_cnt = 0, aw200_cnt = 0;
   logic [31:0]  last_awaddr = '0;
   logic [15:0]  last_wstrb = '0, wstrb_200 = '0;

   always #5 aclk = ~aclk;

   friscv_dcache_wbuf #(
      .AXI_ADDR_W (32),
      .AXI_ID_W   (8),
      .AXI_DATA_W (128),
      .DEPTH      (4)
   ) dut (
      .aclk      (aclk),      .aresetn   (aresetn),   .srst      (srst),
      .s_awvalid (s_awvalid), .s_awready (s_awready), .s_awaddr  (s_awaddr),
      .s_awprot  (s_awprot),  .s_awid    (s_awid),
      .s_wvalid  (s_wvalid),  .s_wready  (s_wready),  .s_wdata   (s_wdata),
      .s_wstrb   (s_wstrb),
      .s_bvalid  (s_bvalid),  .s_bready  (s_bready),  .s_bid     (s_bid),
      .s_bresp   (s_bresp),
      .s_arvalid (s_arvalid), .s_arready (s_arready), .s_araddr  (s_araddr),
      .s_arprot  (s_arprot),  .s_arid    (s_arid),
      .s_rvalid  (s_rvalid),  .s_rready  (s_rready),  .s_rid     (s_rid),
      .s_rresp   (s_rresp),   .s_rdata   (s_rdata),
      .m_awvalid (m_awvalid), .m_awready (m_awready), .m_awaddr  (m_awaddr),
      .m_awprot  (m_awprot),  .m_awid    (m_awid),
      .m_wvalid  (m_wvalid),  .m_wready  (m_wready),  .m_wdata   (m_wdata),
      .m_wstrb   (m_wstrb),
      .m_bvalid  (m_bvalid),  .m_bready  (m_bready),  .m_bid     (m_bid),
      .m_bresp   (m_bresp),
      .m_arvalid (m_arvalid), .m_arready (m_arready), .m_araddr  (m_araddr),
      .m_arprot  (m_arprot),  .m_arid    (m_arid),
      .m_rvalid  (m_rvalid),  .m_rready  (m_rready),  .m_rid     (m_rid),
      .m_rresp   (m_rresp),   .m_rdata   (m_rdata),
      .empty     (empty),     .wr_error  (wr_error)
   );

   assign m_awready = aw_rdy;
   assign m_wready  = w_rdy;
   assign m_bvalid  = bv;
   assign m_bid     = 8'h00;
   assign m_bresp   = b_resp_cfg;
   assign m_arready = 1'b1;
   assign m_rvalid  = rv;
   assign m_rid     = 8'h00;
   assign m_rresp   = 2'b00;
   assign m_rdata   = rd;

   // Memory model is deliberately not reset, so a stale B can follow a DUT reset.
   always @(posedge aclk) begin
      logic [127:0] t;
      if (m_awvalid && m_awready) begin
         aw_done     <= 1'b1;
         aw_cnt      <= aw_cnt + 1;
         last_awaddr <= m_awaddr;
         if (m_awaddr == 32'h200) aw200_cnt <= aw200_cnt + 1;
      end
      if (m_wvalid && m_wready) begin
         w_done     <= 1'b1;
         last_wstrb <= m_wstrb;
         if (m_awaddr == 32'h200) wstrb_200 <= m_wstrb;
         t = mem[m_awaddr[11:4]];
         for (int b = 0; b < 16; b++) if (m_wstrb[b]) t[8*b +: 8] = m_wdata[8*b +: 8];
         mem[m_awaddr[11:4]] <= t;
      end
      if (bv) begin
         bv      <= 1'b0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
         b_cnt   <= b_cnt + 1;
      end else if (aw_done && w_done && b_en) begin
         bv <= 1'b1;
      end
      if (m_arvalid && m_arready) begin
         rv <= 1'b1;
         rd <= mem[m_araddr[11:4]];
      end else if (rv && m_rready) begin
         rv <= 1'b0;
      end
   end

   task automatic do_write(input logic [31:0] a, input logic [15:0] st,
                           input logic [127:0] d, input logic [7:0] id);
      int n = 0;
      @(negedge aclk);
      s_awvalid = 1'b1; s_wvalid = 1'b1;
      s_awaddr = a; s_wstrb = st; s_wdata = d; s_awid = id;
      while (!(s_awready && s_wready) && n < 200) begin
         @(negedge aclk);
         n++;
      end
      n_cmp++;
      if (n >= 200) begin
         n_bad++;
         $display("FAIL write_accept addr=%h: ready=0 after %0d cycles, required 1", a, n);
      end else begin
         @(posedge aclk);
      end
      @(negedge aclk);
      s_awvalid = 1'b0; s_wvalid = 1'b0;
   endtask

   task automatic finish_b();
      s_bready = 1'b1;
      @(negedge aclk);
      s_bready = 1'b0;
   endtask

   task automatic wait_empty(output bit ok);
      int n = 0;
      while (!empty && n < 300) begin
         @(negedge aclk);
         n++;
      end
      ok = empty;
   endtask

   task automatic test_reset();
      n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty: got %b want 1", empty); end
      n_cmp++; if (s_bvalid !== 1'b0) begin n_bad++; $display("FAIL reset_bvalid: got %b want 0", s_bvalid); end
      n_cmp++; if (m_awvalid !== 1'b0 || m_wvalid !== 1'b0) begin
         n_bad++; $display("FAIL reset_m_valid: aw=%b w=%b want 0 0", m_awvalid, m_wvalid); end
      n_cmp++; if (wr_error !== 1'b0) begin n_bad++; $display("FAIL reset_wr_error: got %b want 0", wr_error); end
      n_cmp++; if (s_awready !== 1'b1) begin n_bad++; $display("FAIL reset_awready: got %b want 1", s_awready); end
   endtask

   task automatic test_single_write();
      bit ok;
      do_write(32'h100, 16'h000F, 128'hDEADBEEF_00000000_00000000_11223344, 8'h5A);
      n_cmp++; if (s_bvalid !== 1'b1 || s_bid !== 8'h5A || s_bresp !== 2'b00) begin
         n_bad++; $display("FAIL single_b: valid=%b id=%h resp=%b want 1 5a 00", s_bvalid, s_bid, s_bresp); end
      finish_b();
      n_cmp++; if (s_bvalid !== 1'b0) begin n_bad++; $display("FAIL single_b_drop: got %b want 0", s_bvalid); end
      wait_empty(ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL single_empty: got %b want 1", empty); end
      n_cmp++; if (last_awaddr !== 32'h100 || last_wstrb !== 16'h000F) begin
         n_bad++; $display("FAIL single_maw: addr=%h strb=%h want 100 000f", last_awaddr, last_wstrb); end
      n_cmp++; if (mem[8'h10] !== 128'h00000000_00000000_00000000_11223344) begin
         n_bad++; $display("FAIL single_mem: got %h want 11223344 in low word", mem[8'h10]); end
   endtask

   task automatic test_merge();
      bit ok;
      aw_rdy = 1'b0; w_rdy = 1'b0;
      do_write(32'h500, 16'hFFFF, {4{32'h55555555}}, 8'h01); finish_b();
      do_write(32'h204, 16'h00F0, {4{32'hA1A2A3A4}}, 8'h02); finish_b();
      do_write(32'h208, 16'h0F00, {4{32'hB1B2B3B4}}, 8'h03); finish_b();
      n_cmp++; if (m_awaddr !== 32'h500 || m_awvalid !== 1'b1) begin
         n_bad++; $display("FAIL merge_stalled_head: addr=%h valid=%b want 500 1", m_awaddr, m_awvalid); end
      aw_rdy = 1'b1; w_rdy = 1'b1;
      wait_empty(ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL merge_empty: got %b want 1", empty); end
      n_cmp++; if (aw200_cnt !== 1) begin n_bad++; $display("FAIL merge_aw_count: got %0d want 1", aw200_cnt); end
      n_cmp++; if (wstrb_200 !== 16'h0FF0) begin n_bad++; $display("FAIL merge_strb: got %h want 0ff0", wstrb_200); end
      n_cmp++; if (mem[8'h20] !== 128'h00000000_B1B2B3B4_A1A2A3A4_00000000) begin
         n_bad++; $display("FAIL merge_data: got %h want 00000000b1b2b3b4a1a2a3a400000000", mem[8'h20]); end
   endtask

   task automatic test_full_stall();
      bit ok;
      int n = 0;
      int b0;
      aw_rdy = 1'b0; w_rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         do_write(32'h400 + 32'(16 * i), 16'h0001, 128'(i + 1), 8'(i));
         finish_b();
      end
      @(negedge aclk);
      s_awvalid = 1'b1; s_wvalid = 1'b1;
      s_awaddr = 32'h440; s_wstrb = 16'h0001; s_wdata = 128'h5; s_awid = 8'h04;
      repeat (6) @(negedge aclk);
      n_cmp++; if (s_awready !== 1'b0 || s_wready !== 1'b0) begin
         n_bad++; $display("FAIL full_stall: awready=%b wready=%b want 0 0", s_awready, s_wready); end
      b0 = b_cnt;
      aw_rdy = 1'b1; w_rdy = 1'b1;
      while (!s_awready && n < 200) begin
         @(negedge aclk);
         n++;
      end
      n_cmp++; if (b_cnt !== b0 + 1 || !s_awready) begin
         n_bad++; $display("FAIL full_release: b_beats=%0d ready=%b want %0d 1", b_cnt - b0, s_awready, 1); end
      @(posedge aclk);
      @(negedge aclk);
      s_awvalid = 1'b0; s_wvalid = 1'b0;
      finish_b();
      wait_empty(ok);
      n_cmp++; if (!ok || mem[8'h44] !== 128'h5) begin
         n_bad++; $display("FAIL full_drain: empty=%b mem=%h want 1 5", empty, mem[8'h44]); end
   endtask

   task automatic test_raw_hazard();
      int n = 0;
      aw_rdy = 1'b0; w_rdy = 1'b0;
      do_write(32'h300, 16'hFFFF, 128'h0F0E0D0C_0B0A0908_07060504_03020100, 8'h07);
      finish_b();
      s_arvalid = 1'b1; s_araddr = 32'h30C; s_arprot = 3'b000; s_arid = 8'h09;
      repeat (4) @(negedge aclk);
      n_cmp++; if (m_arvalid !== 1'b0 || s_arready !== 1'b0) begin
         n_bad++; $display("FAIL raw_hold: m_arvalid=%b s_arready=%b want 0 0", m_arvalid, s_arready); end
      aw_rdy = 1'b1; w_rdy = 1'b1;
      while (!s_arready && n < 200) begin
         @(negedge aclk);
         n++;
      end
      @(posedge aclk);
      @(negedge aclk);
      s_arvalid = 1'b0;
      n = 0;
      while (!s_rvalid && n < 50) begin
         @(negedge aclk);
         n++;
      end
      n_cmp++; if (s_rvalid !== 1'b1 || s_rdata !== 128'h0F0E0D0C_0B0A0908_07060504_03020100) begin
         n_bad++; $display("FAIL raw_data: valid=%b data=%h want 1 0f0e0d0c0b0a09080706050403020100",
                           s_rvalid, s_rdata); end
      @(negedge aclk);
   endtask

   task automatic test_bresp_error();
      bit ok;
      b_resp_cfg = 2'b10;
      do_write(32'h600, 16'h0003, 128'h1234, 8'h11); finish_b();
      wait_empty(ok);
      n_cmp++; if (wr_error !== 1'b1) begin n_bad++; $display("FAIL err_set: got %b want 1", wr_error); end
      b_resp_cfg = 2'b00;
      do_write(32'h610, 16'h0003, 128'h5678, 8'h12); finish_b();
      wait_empty(ok);
      n_cmp++; if (wr_error !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b want 1", wr_error); end
      srst = 1'b1;
      @(negedge aclk);
      srst = 1'b0;
      n_cmp++; if (wr_error !== 1'b0 || empty !== 1'b1) begin
         n_bad++; $display("FAIL err_srst: wr_error=%b empty=%b want 0 1", wr_error, empty); end
   endtask

   task automatic test_reset_wait_b();
      int n = 0;
      b_en = 1'b0;
      do_write(32'h700, 16'hFFFF, 128'h77, 8'h21); finish_b();
      while (!(aw_done && w_done) && n < 50) begin
         @(negedge aclk);
         n++;
      end
      @(negedge aclk);
      n_cmp++; if (empty !== 1'b0 || m_awvalid !== 1'b0) begin
         n_bad++; $display("FAIL rst_wb_state: empty=%b awvalid=%b want 0 0", empty, m_awvalid); end
      b_resp_cfg = 2'b10;
      #2 aresetn = 1'b0;
      #1;
      n_cmp++; if (s_bvalid !== 1'b0 || m_awvalid !== 1'b0 || m_wvalid !== 1'b0 ||
                   empty !== 1'b1 || wr_error !== 1'b0 || s_awready !== 1'b1) begin
         n_bad++; $display("FAIL rst_wb_outputs: bv=%b awv=%b wv=%b empty=%b err=%b awr=%b want 0 0 0 1 0 1",
                           s_bvalid, m_awvalid, m_wvalid, empty, wr_error, s_awready); end
      @(negedge aclk);
      aresetn = 1'b1;
      b_en = 1'b1;
      repeat (6) @(negedge aclk);
      n_cmp++; if (empty !== 1'b1 || m_awvalid !== 1'b0 || wr_error !== 1'b0) begin
         n_bad++; $display("FAIL rst_wb_stale_b: empty=%b awv=%b err=%b want 1 0 0",
                           empty, m_awvalid, wr_error); end
      b_resp_cfg = 2'b00;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      aresetn = 1'b0; srst = 1'b0;
      s_awvalid = 1'b0; s_awaddr = '0; s_awprot = '0; s_awid = '0;
      s_wvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_bready = 1'b0;
      s_arvalid = 1'b0; s_araddr = '0; s_arprot = '0; s_arid = '0;
      s_rready = 1'b1;
      repeat (3) @(negedge aclk);
      aresetn = 1'b1;
      @(negedge aclk);
      test_reset();
      test_single_write();
      test_merge();
      test_full_stall();
      test_raw_hazard();
      test_bresp_error();
      test_reset_wait_b();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation time limit reached, required normal finish");
      $fatal(1);
   end

endmodule
